// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg
//   Shared constants for the multiplexed seven-segment scanner.
//   - HEX_SEG        : 16-entry hex glyph table, active-high, bit order gfedcba
//   - DP_BIT         : position of the decimal point inside the 8-bit seg bus
//   - inactive_level : the 8-bit "everything off" level for a given polarity
// ---------------------------------------------------------------------------
package seg_pkg;

    localparam int DP_BIT = 7;

    // Index = nibble value; glyph bits are gfedcba with segment 'a' in bit 0.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,   // 0 1 2 3
        7'h66, 7'h6D, 7'h7D, 7'h07,   // 4 5 6 7
        7'h7F, 7'h6F, 7'h77, 7'h7C,   // 8 9 A b
        7'h39, 7'h5E, 7'h79, 7'h71    // C d E F
    };

    // Off level for an active-low bus is all ones, for active-high all zeros.
    // XOR-ing an active-high pattern with this value also yields the driven
    // pattern in either polarity.
    function automatic logic [7:0] inactive_level(input int active_low);
        return (active_low != 0) ? 8'hFF : 8'h00;
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// ---------------------------------------------------------------------------
// seg_hex_decode
//   Combinational hex-to-seven-segment glyph lookup (active-high).
//   Ports:
//     nibble : in  [3:0]  hex value 0..F
//     segs   : out [6:0]  glyph, bit order gfedcba
// ---------------------------------------------------------------------------
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segs
);

    assign segs = HEX_SEG[nibble];

endmodule

// File: rtl/scan_seg_mux.sv
// ---------------------------------------------------------------------------
// scan_seg_mux
//   Time-multiplexed driver for a common-anode/cathode seven-segment display
//   of NUM_DIGITS digits. One digit is selected per slot of SLOT_CYCLES
//   clocks; a full pass over all digits is a frame. Display inputs are
//   captured once per frame so a frame never shows a mix of old and new data.
//   Features: hex decode, decimal points, per-digit blanking, per-digit
//   blinking, leading-zero suppression, 16-step PWM brightness and a one-cycle
//   anode dead time at the start of every slot.
//
//   Parameters:
//     NUM_DIGITS   : 1..8 digits
//     SLOT_CYCLES  : clocks per digit slot, >= 2
//     BLINK_FRAMES : frames per blink half-period, >= 1
//     ACTIVE_LOW   : 1 -> an/seg are driven active-low
//
//   Ports:
//     clk        : in   rising-edge clock
//     rst        : in   asynchronous active-high reset
//     en         : in   scan enable; counters hold and outputs go dark when 0
//     digits     : in   4*NUM_DIGITS hex nibbles, digit 0 in [3:0]
//     dp         : in   decimal point per digit
//     blank      : in   force digit dark
//     blink      : in   digit blinks with the blink phase
//     lz_en      : in   leading-zero suppression enable
//     bright     : in   brightness 0..15 (duty = (bright+1)/16)
//     an         : out  registered digit select, one-hot when lit
//     seg        : out  registered segments, bit7 = dp, [6:0] = gfedcba
//     frame_tick : out  high during the first cycle of each frame (the cycle
//                       in which the snapshot is captured)
// ---------------------------------------------------------------------------
module scan_seg_mux
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 6,
    parameter int SLOT_CYCLES  = 1000,
    parameter int BLINK_FRAMES = 64,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic [NUM_DIGITS-1:0]   blink,
    input  logic                    lz_en,
    input  logic [3:0]              bright,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [7:0]              seg,
    output logic                    frame_tick
);

    localparam int SW = $clog2(SLOT_CYCLES);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [SW-1:0] SLOT_LAST  = SW'(SLOT_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    localparam logic [7:0]            SEG_OFF = inactive_level(ACTIVE_LOW);
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{SEG_OFF[0]}};

    // ------------------------------------------------------------------
    // Scan state
    // ------------------------------------------------------------------
    logic [SW-1:0] slot_cnt;
    logic [IW-1:0] idx;
    logic [3:0]    pwm_cnt;
    logic [BW-1:0] blink_cnt;
    logic          blink_flag;

    // Per-frame snapshot; snap_phase freezes the blink phase for the frame.
    logic [4*NUM_DIGITS-1:0] snap_digits;
    logic [NUM_DIGITS-1:0]   snap_dp;
    logic [NUM_DIGITS-1:0]   snap_blank;
    logic [NUM_DIGITS-1:0]   snap_blink;
    logic                    snap_phase;

    logic slot_last;
    logic idx_last;
    logic frame_start;

    assign slot_last = (slot_cnt == SLOT_LAST);
    assign idx_last  = (idx == IDX_LAST);

    // A frame begins in the first enabled cycle at index 0 / slot cycle 0.
    // This covers both the wrap from the last digit and the very first
    // enabled cycle after reset, and fires once even if en stalls there.
    // The anode is dark in that cycle (dead time), so capturing on its edge
    // means every lit cycle of the frame sees the new snapshot.
    assign frame_start = en && (slot_cnt == '0) && (idx == '0);
    assign frame_tick  = frame_start && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_cnt    <= '0;
            idx         <= '0;
            pwm_cnt     <= '0;
            blink_cnt   <= '0;
            blink_flag  <= 1'b0;
            snap_digits <= '0;
            snap_dp     <= '0;
            snap_blank  <= '0;
            snap_blink  <= '0;
            snap_phase  <= 1'b0;
        end else if (en) begin
            pwm_cnt <= pwm_cnt + 4'd1;

            if (slot_last) begin
                slot_cnt <= '0;
                idx      <= idx_last ? '0 : idx + IW'(1);
            end else begin
                slot_cnt <= slot_cnt + SW'(1);
            end

            if (frame_start) begin
                snap_digits <= digits;
                snap_dp     <= dp;
                snap_blank  <= blank;
                snap_blink  <= blink;
                snap_phase  <= blink_flag;
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt  <= '0;
                    blink_flag <= ~blink_flag;
                end else begin
                    blink_cnt <= blink_cnt + BW'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Display decision for the current index (active-high internally)
    // ------------------------------------------------------------------
    logic [NUM_DIGITS-1:0] lz_dark;
    logic                  lz_run;
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_blank;
    logic                  cur_blink;
    logic                  cur_lz;
    logic                  digit_dark;
    logic                  an_lit;
    logic [6:0]            hex_segs;
    logic [7:0]            seg_on;
    logic [NUM_DIGITS-1:0] an_on;

    seg_hex_decode u_hex_decode (
        .nibble (cur_nib),
        .segs   (hex_segs)
    );

    // Leading-zero run: walk down from the top digit while every digit seen
    // so far is zero. Digit 0 is never part of the run.
    always_comb begin
        lz_dark = '0;
        lz_run  = lz_en;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            lz_run     = lz_run && (snap_digits[4*i +: 4] == 4'h0);
            lz_dark[i] = lz_run;
        end
    end

    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        cur_blink = 1'b0;
        cur_lz    = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_nib   = snap_digits[4*i +: 4];
                cur_dp    = snap_dp[i];
                cur_blank = snap_blank[i];
                cur_blink = snap_blink[i];
                cur_lz    = lz_dark[i];
            end
        end
    end

    always_comb begin
        // Blank and blink-off kill the whole digit including dp; leading-zero
        // suppression only kills the glyph.
        digit_dark = cur_blank || (cur_blink && snap_phase);

        seg_on = 8'h00;
        if (!digit_dark) begin
            seg_on[DP_BIT] = cur_dp;
            if (!cur_lz) begin
                seg_on[6:0] = hex_segs;
            end
        end

        // Anode follows the scan regardless of darkness, gated by the slot
        // dead time and the PWM duty.
        an_lit = (slot_cnt != '0) && (pwm_cnt <= bright);
        an_on  = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            an_on[i] = an_lit && (idx == IW'(i));
        end
    end

    // ------------------------------------------------------------------
    // Registered, polarity-adjusted outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
        end else if (!en) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
        end else begin
            an  <= an_on ^ AN_OFF;
            seg <= seg_on ^ SEG_OFF;
        end
    end

endmodule

// File: tb/tb_scan_seg_mux.sv
// ---------------------------------------------------------------------------
// tb_scan_seg_mux
//   Self-checking bench for scan_seg_mux.
//   dut   : NUM_DIGITS=6, SLOT_CYCLES=4,  BLINK_FRAMES=2,  ACTIVE_LOW=1
//   dut_b : NUM_DIGITS=6, SLOT_CYCLES=32, BLINK_FRAMES=64, ACTIVE_LOW=0
// ---------------------------------------------------------------------------
module tb_scan_seg_mux;

  localparam int N = 6;
  localparam int S = 4;
  localparam int B = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        en;
  logic        en_b;
  logic [23:0] digits;
  logic [5:0]  dp;
  logic [5:0]  blank;
  logic [5:0]  blink;
  logic        lz_en;
  logic [3:0]  bright;
  logic [3:0]  bright_b;
  logic [5:0]  an;
  logic [7:0]  seg;
  logic        frame_tick;
  logic [5:0]  an_b;
  logic [7:0]  seg_b;
  logic        frame_tick_b;

  scan_seg_mux #(
    .NUM_DIGITS   (N),
    .SLOT_CYCLES  (S),
    .BLINK_FRAMES (B),
    .ACTIVE_LOW   (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .digits     (digits),
    .dp         (dp),
    .blank      (blank),
    .blink      (blink),
    .lz_en      (lz_en),
    .bright     (bright),
    .an         (an),
    .seg        (seg),
    .frame_tick (frame_tick)
  );

  scan_seg_mux #(
    .NUM_DIGITS   (6),
    .SLOT_CYCLES  (32),
    .BLINK_FRAMES (64),
    .ACTIVE_LOW   (0)
  ) dut_b (
    .clk        (clk),
    .rst        (rst),
    .en         (en_b),
    .digits     (digits),
    .dp         (dp),
    .blank      (blank),
    .blink      (blink),
    .lz_en      (lz_en),
    .bright     (bright_b),
    .an         (an_b),
    .seg        (seg_b),
    .frame_tick (frame_tick_b)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // gfedcba glyphs, active-high
  logic [6:0] hex_tab [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  int          m_slot;
  int          m_idx;
  int          m_pwm;
  int          m_frame;
  int          kb;
  logic [23:0] s_dig;
  logic [5:0]  s_dp;
  logic [5:0]  s_blank;
  logic [5:0]  s_blink;

  // scoreboard: {check_seg, an[5:0], seg[7:0]} for dut, {counted, an} for dut_b
  logic [14:0] exp_q[$];
  logic [6:0]  exp_b_q[$];

  // directed observations
  logic [7:0] seen_seg [8][6];
  logic [5:0] rot_seen [6];
  int         rot_n = 0;
  logic [5:0] last_lit = 6'h3F;
  int         obs_frame = -1;
  int         tick_cyc [8];
  int         cyc = 0;
  int         b_cycles = 0;
  int         b_active = 0;

  task automatic model_reset();
    m_slot  = 0;
    m_idx   = 0;
    m_pwm   = 0;
    m_frame = -1;
    kb      = 0;
    s_dig   = '0;
    s_dp    = '0;
    s_blank = '0;
    s_blink = '0;
  endtask

  // Active-high segment pattern the display should show for digit i.
  function automatic logic [7:0] model_seg(input int i);
    logic       phase;
    logic       sup;
    logic [7:0] r;
    logic [3:0] nib;
    phase = (m_frame >= 0) ? (((m_frame / B) % 2) == 1) : 1'b0;
    sup = lz_en && (i != 0);
    for (int j = i; j < N; j++) begin
      if (s_dig[4*j +: 4] != 4'h0) sup = 1'b0;
    end
    r = 8'h00;
    if (!(s_blank[i] || (s_blink[i] && phase))) begin
      nib  = s_dig[4*i +: 4];
      r[7] = s_dp[i];
      r[6:0] = sup ? 7'h00 : hex_tab[nib];
    end
    return r;
  endfunction

  // ---------------- driver: one clock cycle ----------------
  // Called right after a falling edge with this cycle's inputs already set.
  task automatic tick_cycle();
    logic [14:0] e;
    logic [6:0]  eb;
    logic        lit;
    logic [5:0]  an_h;
    logic [7:0]  sg;
    #1;
    check_eq("frame_tick", frame_tick, (!rst && en && m_slot == 0 && m_idx == 0));
    if (frame_tick) begin
      obs_frame++;
      if (obs_frame >= 0 && obs_frame < 8) tick_cyc[obs_frame] = cyc;
    end
    if (rst) begin
      exp_q.push_back({1'b1, 6'h3F, 8'hFF});
      exp_b_q.push_back(7'h00);
      model_reset();
    end else begin
      if (!en) begin
        exp_q.push_back({1'b1, 6'h3F, 8'hFF});
      end else begin
        lit  = (m_slot != 0) && (m_pwm <= int'(bright));
        an_h = lit ? 6'(1 << m_idx) : 6'h00;
        sg   = model_seg(m_idx);
        exp_q.push_back({lit, ~an_h, ~sg});
        if (m_slot == 0 && m_idx == 0) begin
          m_frame++;
          s_dig   = digits;
          s_dp    = dp;
          s_blank = blank;
          s_blink = blink;
        end
        m_pwm = (m_pwm + 1) % 16;
        if (m_slot == S - 1) begin
          m_slot = 0;
          m_idx  = (m_idx + 1) % N;
        end else begin
          m_slot++;
        end
      end
      eb = {1'b1, ((kb % 32 != 0) && (kb % 16 <= 3)) ? 6'(1 << ((kb / 32) % 6)) : 6'h00};
      exp_b_q.push_back(eb);
      kb++;
    end

    @(negedge clk);
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("an", an, e[13:8]);
      if (e[14]) check_eq("seg", seg, e[7:0]);
      for (int i = 0; i < N; i++) begin
        if (an == ~(6'b000001 << i)) begin
          if (obs_frame >= 0 && obs_frame < 8) seen_seg[obs_frame][i] = seg;
          if (an != last_lit && rot_n < 6) begin
            rot_seen[rot_n] = an;
            rot_n++;
          end
          last_lit = an;
        end
      end
    end
    if (exp_b_q.size() > 0) begin
      eb = exp_b_q.pop_front();
      check_eq("an_b", an_b, eb[5:0]);
      if (eb[6] && b_cycles < 64) begin
        b_cycles++;
        if (an_b != 6'h00) b_active++;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  logic [5:0] rot_exp [6] = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
  logic [7:0] f1_exp  [6] = '{8'hA4, 8'hF9, 8'hC0, 8'h88, 8'hFF, 8'hFF};

  initial begin
    for (int f = 0; f < 8; f++)
      for (int d = 0; d < 6; d++)
        seen_seg[f][d] = 8'h00;

    rst      = 1'b1;
    en       = 1'b1;
    en_b     = 1'b1;
    digits   = 24'h00A012;
    dp       = 6'h00;
    blank    = 6'h00;
    blink    = 6'h01;
    lz_en    = 1'b1;
    bright   = 4'd15;
    bright_b = 4'd3;
    model_reset();

    // reset holds everything dark
    repeat (3) begin
      tick_cycle();
      check_eq("an_rst", an, 6'h3F);
      check_eq("seg_rst", seg, 8'hFF);
      check_eq("an_b_rst", an_b, 6'h00);
      check_eq("seg_b_rst", seg_b, 8'h00);
      check_eq("tick_b_rst", frame_tick_b, 1'b0);
    end
    rst = 1'b0;

    // six frames; digits change in the middle of frame 3
    for (int c = 0; c < 6 * N * S; c++) begin
      if (c == 3 * N * S + 5) digits = 24'h123456;
      tick_cycle();
    end

    for (int i = 0; i < 6; i++)
      check_eq($sformatf("rot%0d", i), rot_seen[i], rot_exp[i]);
    check_eq("tick_gap0", tick_cyc[1] - tick_cyc[0], N * S);
    check_eq("tick_gap1", tick_cyc[2] - tick_cyc[1], N * S);
    for (int d = 0; d < 6; d++)
      check_eq($sformatf("f1_dig%0d", d), seen_seg[1][d], f1_exp[d]);
    check_eq("blink_f2_d0", seen_seg[2][0], 8'hFF);
    check_eq("blink_f3_d0", seen_seg[3][0], 8'hFF);
    check_eq("blink_f2_d1", seen_seg[2][1], 8'hF9);
    check_eq("blink_f4_d0", seen_seg[4][0], 8'h82);
    check_eq("blink_f5_d0", seen_seg[5][0], 8'h82);
    check_eq("tear_f3_d5", seen_seg[3][5], 8'hFF);
    check_eq("tear_f3_d2", seen_seg[3][2], 8'hC0);
    check_eq("tear_f4_d5", seen_seg[4][5], 8'hF9);
    check_eq("b_duty", b_active, 14);

    // drop en inside slot 2, then resume
    blink = 6'h00;
    repeat (2 * S + 1) tick_cycle();
    en = 1'b0;
    repeat (6) tick_cycle();
    en = 1'b1;
    repeat (30) tick_cycle();

    // random traffic with a reset in the middle
    for (int c = 0; c < 400; c++) begin
      if (c % 8 == 0) begin
        digits = {$urandom_range(0, 16'hFFFF), $urandom_range(0, 8'hFF)};
        if ($urandom_range(0, 1) == 1) digits[23:12] = 12'h000;
        dp     = 6'($urandom_range(0, 63));
        blank  = 6'($urandom_range(0, 63) & $urandom_range(0, 63));
        blink  = 6'($urandom_range(0, 63) & $urandom_range(0, 63));
        lz_en  = 1'($urandom_range(0, 1));
      end
      if (c % 16 == 0) bright = 4'($urandom_range(0, 15));
      en  = ($urandom_range(0, 9) != 0);
      rst = (c == 200 || c == 201);
      tick_cycle();
    end
    rst = 1'b0;

    check_eq("sb_drain", exp_q.size(), 0);
    check_eq("sb_b_drain", exp_b_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_seg_mux.md
SCAN_SEG_MUX -- requirements
Module: scan_seg_mux

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 6: digit count, legal range 1..8.
REQ-002 SHALL have parameter SLOT_CYCLES, default 1000: clk cycles per digit slot, at least 2.
REQ-003 SHALL have parameter BLINK_FRAMES, default 64: frames per blink half-period, at least 1.
REQ-004 SHALL have parameter ACTIVE_LOW, default 1: when 1, both an and seg are driven active-low.
REQ-005 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port en, input, 1 bit: scan enable.
REQ-008 SHALL have port digits, input, 4*NUM_DIGITS bits: hex nibble per digit, digit 0 in bits [3:0].
REQ-009 SHALL have port dp, input, NUM_DIGITS bits: decimal point per digit.
REQ-010 SHALL have port blank, input, NUM_DIGITS bits: force digit dark.
REQ-011 SHALL have port blink, input, NUM_DIGITS bits: digit blinks.
REQ-012 SHALL have port lz_en, input, 1 bit: enables leading-zero suppression.
REQ-013 SHALL have port bright, input, 4 bits: brightness level.
REQ-014 SHALL have port an, output, NUM_DIGITS bits: digit select, one-hot when lit.
REQ-015 SHALL have port seg, output, 8 bits: bit7 = dp, bits[6:0] = gfedcba.
REQ-016 SHALL have port frame_tick, output, 1 bit: one-cycle pulse at the start of each frame.

Function
REQ-017 A slot counter SHALL count 0..SLOT_CYCLES-1 while en=1; at terminal count the digit index SHALL advance, wrapping from NUM_DIGITS-1 to 0.
REQ-018 When the index wraps to 0, digits, dp, blank and blink SHALL be captured into a frame snapshot, and frame_tick SHALL pulse for that cycle; all display decisions within a frame SHALL use only the snapshot (no tearing).
REQ-019 Decode SHALL cover full hex, gfedcba: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-020 With lz_en=1, snapshot digits equal to 0 SHALL be dark from digit NUM_DIGITS-1 downward until the first non-zero digit; digit 0 SHALL never be suppressed; dp of a suppressed digit SHALL still display.
REQ-021 A blink phase flag SHALL toggle every BLINK_FRAMES frames; while the flag is 1, digits with a blink bit set SHALL be dark, including dp.
REQ-022 A dark digit SHALL have all segments inactive; its anode SHALL still follow the scan.
REQ-023 A free-running 4-bit PWM counter SHALL be kept; the anode SHALL be active only while pwm_cnt <= bright (bright=15 means full on, bright=0 means 1/16 duty).
REQ-024 The anode SHALL be inactive during slot-counter cycle 0 of every slot (anti-ghost dead time).
REQ-025 an and seg SHALL be registered, reflecting the index and slot count of the previous cycle (1-cycle latency).
REQ-026 With en=0, the counters SHALL hold and an/seg SHALL be inactive on the next edge; on en returning to 1, scanning SHALL resume from the held index.
REQ-027 Inactive SHALL mean all ones when ACTIVE_LOW=1 and all zeros when ACTIVE_LOW=0.
REQ-028 If rst and a wrap occur in the same cycle, reset SHALL win.

Reset
REQ-029 While rst=1, the slot counter, index, PWM counter, blink counter and blink flag SHALL be 0, the snapshot SHALL be all zero, an and seg SHALL be inactive, and frame_tick SHALL be 0.
REQ-030 After rst falls, the first snapshot capture and frame_tick SHALL occur on the first en=1 cycle; assertion of rst mid-frame SHALL abort the frame immediately.

Structure
REQ-031 Package seg_pkg SHALL hold the 16-entry hex segment table, the DP bit index and the inactive-level helper constant.
REQ-032 The hex decoder SHALL be the combinational sub-module seg_hex_decode (4-bit in, 7-bit gfedcba out).

Verification
REQ-033 Reset release with NUM_DIGITS=6, SLOT_CYCLES=4, ACTIVE_LOW=1: an=3F and seg=FF during reset; frame_tick every 24 cycles; lit anodes rotate 3E,3D,3B,37,2F,1F.
REQ-034 digits=0x00A012, lz_en=1, bright=15: digits 5 and 4 dark, digit 3 seg=88, digit 2 seg=C0, digit 1 seg=F9, digit 0 seg=A4.
REQ-035 Change digits mid-frame: the displayed values change only after the next frame_tick.
REQ-036 blink=0x01, BLINK_FRAMES=2: digit 0 is dark for frames 2-3, lit for frames 4-5; other digits are never dark.
REQ-037 bright=3, SLOT_CYCLES=32: the lit anode is active 4 of every 16 cycles, and never in slot cycle 0.
REQ-038 Drop en in slot 2: an=3F on the next edge; the index holds; scanning resumes at slot 2 when en returns.
